// File: rtl/bitwise_reduce_pipe.sv
// bitwise_reduce_pipe: two-stage valid/ready pipeline reducing NUM_IN operands bitwise by AND/OR/XOR/bypass.
// Define BITRED_PARITY_EN to add a registered out_parity (XOR of all out_data bits).
module bitwise_reduce_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [1:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data
`ifdef BITRED_PARITY_EN
    ,
    output logic                    out_parity
`endif
);
    logic                    s1_valid_q, s1_valid_d;
    logic [NUM_IN*WIDTH-1:0] s1_data_q, s1_data_d;
    logic [1:0]              s1_op_q, s1_op_d;
    logic                    out_valid_q, out_valid_d;
    logic [WIDTH-1:0]        out_data_q, out_data_d, red;
    logic                    s2_adv, s1_adv;

    always_comb begin
        red = s1_data_q[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            red = s1_op_q == 2'b00 ? red & s1_data_q[k*WIDTH +: WIDTH] :
                  s1_op_q == 2'b01 ? red | s1_data_q[k*WIDTH +: WIDTH] :
                  s1_op_q == 2'b10 ? red ^ s1_data_q[k*WIDTH +: WIDTH] : red;
        end
    end

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // S1 data is only refreshed on a handshake; stale contents behind a clear valid are don't-care
    always_comb begin
        s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
        s1_data_d   = s1_adv && in_valid ? in_data : s1_data_q;
        s1_op_d     = s1_adv && in_valid ? in_op : s1_op_q;
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        out_data_d  = s2_adv && s1_valid_q ? red : out_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_op_q     <= 2'b00;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef BITRED_PARITY_EN
    logic parity_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_q <= 1'b0;
        else parity_q <= ^out_data_d;
    end
    assign out_parity = parity_q;
`endif
endmodule

// File: tb/tb_bitwise_reduce_pipe.sv
// tb_bitwise_reduce_pipe: directed checks of reset, op sequence, back-pressure and boundaries, plus random handshake scoreboard.
module tb_bitwise_reduce_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid, a_in_ready, a_out_valid, a_ordy;
    logic [23:0] a_data;
    logic [1:0]  a_op;
    logic [7:0]  a_out_data;
`ifdef BITRED_PARITY_EN
    logic        a_out_parity;
`endif

    logic        b_valid, b_in_ready, b_out_valid, b_ordy;
    logic [79:0] b_data;
    logic [1:0]  b_op;
    logic [15:0] b_out_data;
`ifdef BITRED_PARITY_EN
    logic        b_out_parity;
`endif

    logic        c_valid, c_in_ready, c_out_valid, c_ordy;
    logic [63:0] c_data;
    logic [1:0]  c_op;
    logic [15:0] c_out_data;
`ifdef BITRED_PARITY_EN
    logic        c_out_parity;
`endif

    bitwise_reduce_pipe #(.WIDTH(8), .NUM_IN(3)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_in_ready), .in_data(a_data), .in_op(a_op),
        .out_valid(a_out_valid), .out_ready(a_ordy), .out_data(a_out_data)
`ifdef BITRED_PARITY_EN
        , .out_parity(a_out_parity)
`endif
    );

    bitwise_reduce_pipe #(.WIDTH(16), .NUM_IN(5)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_in_ready), .in_data(b_data), .in_op(b_op),
        .out_valid(b_out_valid), .out_ready(b_ordy), .out_data(b_out_data)
`ifdef BITRED_PARITY_EN
        , .out_parity(b_out_parity)
`endif
    );

    bitwise_reduce_pipe #(.WIDTH(16), .NUM_IN(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_in_ready), .in_data(c_data), .in_op(c_op),
        .out_valid(c_out_valid), .out_ready(c_ordy), .out_data(c_out_data)
`ifdef BITRED_PARITY_EN
        , .out_parity(c_out_parity)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref16(input logic [79:0] d, input logic [1:0] op);
        logic [15:0] r;
        r = op == 2'd0 ? 16'hFFFF : 16'h0000;
        for (int k = 0; k < 5; k++) begin
            case (op)
                2'd0: r = r & d[k*16 +: 16];
                2'd1: r = r | d[k*16 +: 16];
                2'd2: r = r ^ d[k*16 +: 16];
                default: r = d[15:0];
            endcase
        end
        return r;
    endfunction

    logic [23:0] sd [5];
    logic [1:0]  so [5];
    logic [7:0]  se [5];
    logic        sp [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, rcv, cyc;
        logic b_acc;
        logic [15:0] q[$];
        sd = '{24'hFF3CF0, 24'hFF3CF0, 24'hFF3CF0, 24'hFF3CF0, 24'h000031};
        so = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        se = '{8'h30, 8'hFF, 8'h33, 8'hF0, 8'h31};
        sp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        a_valid = 0; a_ordy = 1; a_data = '0; a_op = 0;
        b_valid = 0; b_ordy = 1; b_data = '0; b_op = 0;
        c_valid = 0; c_ordy = 1; c_data = '0; c_op = 0;

        step;
        step;
        check("rst_valid", 32'(a_out_valid), 0);
        check("rst_data", 32'(a_out_data), 0);
`ifdef BITRED_PARITY_EN
        check("rst_parity", 32'(a_out_parity), 0);
`endif
        rst = 0;
        #1;
        check("rst_in_ready", 32'(a_in_ready), 1);
        step;

        a_valid = 1; a_data = sd[0]; a_op = 2'd0;
        step;
        a_data = sd[1]; a_op = 2'd1;
        step;
        a_valid = 0;
        rst = 1;
        #1;
        check("midrst_valid", 32'(a_out_valid), 0);
        check("midrst_data", 32'(a_out_data), 0);
        step;
        rst = 0;
        #1;
        check("midrst_in_ready", 32'(a_in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            step;
            check("midrst_no_out", 32'(a_out_valid), 0);
        end

        a_ordy = 1;
        for (int i = 0; i < 7; i++) begin
            if (i >= 2) begin
                check("seq_valid", 32'(a_out_valid), 1);
                check("seq_data", 32'(a_out_data), 32'(se[i-2]));
`ifdef BITRED_PARITY_EN
                check("seq_parity", 32'(a_out_parity), 32'(sp[i-2]));
`endif
            end else begin
                check("seq_idle", 32'(a_out_valid), 0);
            end
            a_valid = i < 5;
            if (i < 5) begin
                a_data = sd[i];
                a_op = so[i];
            end
            step;
        end
        check("seq_drained", 32'(a_out_valid), 0);

        a_ordy = 0; a_valid = 1; a_data = sd[0]; a_op = so[0];
        #1;
        check("bp_rdy_first", 32'(a_in_ready), 1);
        step;
        a_op = so[1];
        #1;
        check("bp_rdy_second", 32'(a_in_ready), 1);
        check("bp_no_out", 32'(a_out_valid), 0);
        step;
        a_op = so[2];
        #1;
        check("bp_rdy_drop", 32'(a_in_ready), 0);
        step;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", 32'(a_out_valid), 1);
            check("bp_hold_data", 32'(a_out_data), 32'h30);
            check("bp_rdy_low", 32'(a_in_ready), 0);
            step;
        end
        a_ordy = 1;
        #1;
        check("bp_rdy_release", 32'(a_in_ready), 1);
        step;
        check("bp_out_or", 32'(a_out_data), 32'hFF);
        a_op = so[3];
        step;
        check("bp_out_xor", 32'(a_out_data), 32'h33);
        a_valid = 0;
        step;
        check("bp_out_byp", 32'(a_out_data), 32'hF0);
        check("bp_out_byp_valid", 32'(a_out_valid), 1);
        step;
        check("bp_drained", 32'(a_out_valid), 0);

        c_valid = 1; c_op = 2'd2; c_data = 64'h0;
        step;
        c_data = {64{1'b1}};
        step;
        c_valid = 0;
        check("xor4_zero_valid", 32'(c_out_valid), 1);
        check("xor4_zero", 32'(c_out_data), 32'h0000);
        step;
        check("xor4_ones_valid", 32'(c_out_valid), 1);
        check("xor4_ones", 32'(c_out_data), 32'h0000);

        sent = 0; rcv = 0; cyc = 0; b_acc = 0;
        while ((sent < 1000 || rcv < sent) && cyc < 20000) begin
            if (!b_valid || b_acc) begin
                b_valid = sent < 1000 && $urandom_range(0, 3) != 0;
                for (int k = 0; k < 5; k++) b_data[k*16 +: 16] = 16'($urandom);
                b_op = 2'($urandom);
            end
            b_ordy = $urandom_range(0, 3) != 0;
            #1;
            b_acc = b_valid && b_in_ready;
            if (b_out_valid && b_ordy) begin
                check("rnd_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) check("rnd_data", 32'(b_out_data), 32'(q.pop_front()));
                rcv++;
            end
            if (b_acc) begin
                q.push_back(ref16(b_data, b_op));
                sent++;
            end
            step;
            cyc++;
        end
        check("rnd_received", 32'(rcv), 1000);

        b_valid = 1; b_ordy = 1; b_op = 2'd2; b_data = {80{1'b1}};
        step;
        b_valid = 0;
        step;
        check("xor5_ones_valid", 32'(b_out_valid), 1);
        check("xor5_ones", 32'(b_out_data), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
